reg_bank_2r1w: RTL and testbench
================================

// Module: reg_bank_2r1w
// PURPOSE
//   Parametrised register bank; the successor to the single 8-bit enable register.
//   Provides DEPTH registers of WIDTH bits, one write port and two independent read ports.
//   Serves as the RISC CPU general-purpose register file. The ALU reads operands A/B;
//   writeback drives the write port.
//   Writes commit on the falling Clk edge, so posedge pipeline logic always sees settled values.
// PARAMETERS
//   WIDTH     8   data width of each register, in bits
//   DEPTH     8   number of registers (2..256; need not be a power of 2)
//   AW        3   address width; must equal $clog2(DEPTH)
//   ZERO_REG  1   1: register 0 is hard-wired to 0 and writes to it are dropped;
//                 0: register 0 is an ordinary register
// PORTS
//   Clk      in   1      clock; all state updates on negedge
//   Rst      in   1      reset, synchronous, active-high
//   Cen      in   1      global clock enable; 0 freezes all state
//   WrEn     in   1      write request
//   WrAddr   in   AW     write address
//   WrData   in   WIDTH  write data
//   RdAddrA  in   AW     read address, port A
//   RdDataA  out  WIDTH  read data, port A (combinational from storage)
//   RdAddrB  in   AW     read address, port B
//   RdDataB  out  WIDTH  read data, port B (combinational from storage)
// BEHAVIOUR
//   - Reset: on a negedge with Rst=1, all DEPTH registers clear to 0 in that single edge.
//     * Rst has priority over Cen and WrEn.
//     * After reset, both read ports return 0 for every address.
//   - Write: on a negedge with Rst=0, Cen=1, WrEn=1 and a legal WrAddr, mem[WrAddr] <= WrData.
//     * Latency: 1 falling edge. The new value is visible on read ports immediately after that edge.
//   - Dropped writes (storage unchanged, no error flag):
//     * WrAddr >= DEPTH (only possible when DEPTH is not a power of 2);
//     * WrAddr == 0 when ZERO_REG=1;
//     * Cen=0, regardless of WrEn.
//   - Read: RdDataX = mem[RdAddrX] through a pure combinational mux, with no clock latency.
//     * Returns 0 when RdAddrX >= DEPTH.
//     * Returns 0 when RdAddrX == 0 and ZERO_REG=1.
//   - Simultaneous read and write to the same address (no bypass):
//     * the read returns the OLD value until the committing negedge;
//     * from that negedge on, it returns WrData.
//   - Both read ports may address the same register; each returns the identical value.
//   - Reset asserted mid-sequence (e.g. between two writes) wipes all prior writes.
//     The first write after Rst deasserts lands normally.
//   - Cen low for N cycles followed by high: no state change occurs during the N cycles,
//     and no writes are queued for later.
//   - No internal state besides the DEPTH x WIDTH array; no FSM. Bypass logic is listed below.
// CONFIGURATION
//   Macro: REG_BANK_BYPASS_EN
//   - Defined: write-through forwarding. When all of the following hold, RdDataX = WrData
//     combinationally, before the commit edge:
//     * Rst=0, Cen=1, WrEn=1;
//     * the write is legal (not dropped);
//     * RdAddrX == WrAddr.
//     Forwarding applies independently per port. A dropped write (reg0 with ZERO_REG=1,
//     out of range, Cen=0) is never forwarded.
//   - Undefined: no forwarding logic is synthesised; reads follow storage only, per BEHAVIOUR.
// TESTING
//   1. Pulse Rst for 1 negedge after writing 0xFF to all regs
//      -> every address reads 0x00 on A and B.
//   2. Cen=1, WrEn=1, WrAddr=3, WrData=0xA5; RdAddrA=3
//      -> A=0x00 before the negedge, 0xA5 after it.
//      With REG_BANK_BYPASS_EN: A=0xA5 as soon as the inputs settle.
//   3. ZERO_REG=1: write 0x5A to addr 0
//      -> RdDataA(addr 0)=0x00, before and after the edge, with or without bypass.
//   4. Cen=0, WrEn=1, WrAddr=5, WrData=0x3C for 4 negedges, then Cen=1 with WrEn=0
//      -> reg5 keeps its prior value 0x11.
//   5. DEPTH=6: write 0x77 to addr 7; read addr 7
//      -> reads 0x00; regs 0..5 unchanged.
//   6. Write 0x12 to r1 and 0x34 to r2; RdAddrA=1, RdAddrB=2, then both=2
//      -> (0x12,0x34), then (0x34,0x34).
//      Asserting Rst together with WrEn to r2 -> r2=0x00 (reset wins).

Source files
------------

// File: rtl/reg_bank_2r1w_if.sv
// Operand/writeback bus of the register bank: clock enable, one write port, two read ports.
// Master drives addresses and write data; slave (the bank) returns read data.
interface reg_bank_2r1w_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
);
  logic             Cen;
  logic             WrEn;
  logic [AW-1:0]    WrAddr;
  logic [WIDTH-1:0] WrData;
  logic [AW-1:0]    RdAddrA;
  logic [WIDTH-1:0] RdDataA;
  logic [AW-1:0]    RdAddrB;
  logic [WIDTH-1:0] RdDataB;

  modport master (
    output Cen, WrEn, WrAddr, WrData, RdAddrA, RdAddrB,
    input  RdDataA, RdDataB
  );

  modport slave (
    input  Cen, WrEn, WrAddr, WrData, RdAddrA, RdAddrB,
    output RdDataA, RdDataB
  );
endinterface

// File: rtl/reg_bank_2r1w.sv
// DEPTH x WIDTH register file, one write port committing on the falling clock edge, two
// combinational read ports. Optional write-through forwarding via macro REG_BANK_BYPASS_EN.
module reg_bank_2r1w #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = 3,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic            Clk,
  input logic            Rst,
  reg_bank_2r1w_if.slave bus
);

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // True for addresses that map onto real, writable storage.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DepthW) && !(ZERO_REG && (a == '0));
  endfunction

  function automatic logic [WIDTH-1:0] rd_port(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if (addr_ok(a)) begin
      v = mem[a];
    end
    return v;
  endfunction

  assign wr_ok = !Rst && bus.Cen && bus.WrEn && addr_ok(bus.WrAddr);

  // Falling-edge commit so posedge consumers always see settled operands.
  always_ff @(negedge Clk) begin
    if (Rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[bus.WrAddr] <= bus.WrData;
    end
  end

  always_comb begin
    rd_a = rd_port(bus.RdAddrA);
    rd_b = rd_port(bus.RdAddrB);
`ifdef REG_BANK_BYPASS_EN
    // Only legal, enabled writes are forwarded; dropped writes never leak onto the ports.
    if (wr_ok && (bus.RdAddrA == bus.WrAddr)) begin
      rd_a = bus.WrData;
    end
    if (wr_ok && (bus.RdAddrB == bus.WrAddr)) begin
      rd_b = bus.WrData;
    end
`endif
  end

  assign bus.RdDataA = rd_a;
  assign bus.RdDataB = rd_b;

endmodule

// File: tb/tb_reg_bank_2r1w.sv
// Scoreboard bench for reg_bank_2r1w (DEPTH=6, ZERO_REG=1): stimulus queues expected read
// data, a posedge monitor pops and compares. Expectations follow REG_BANK_BYPASS_EN.
module tb_reg_bank_2r1w;

`ifdef REG_BANK_BYPASS_EN
  localparam bit Bp = 1'b1;
`else
  localparam bit Bp = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    string      nm;
  } exp_t;

  logic Clk;
  logic Rst;
  exp_t q[$];
  int   n_cmp;
  int   n_bad;

  reg_bank_2r1w_if #(.WIDTH(8), .AW(3)) bus ();

  reg_bank_2r1w #(
    .WIDTH   (8),
    .DEPTH   (6),
    .AW      (3),
    .ZERO_REG(1'b1)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Monitor: outputs are sampled at posedge, midway between committing negedges.
  always @(posedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (bus.RdDataA !== e.a || bus.RdDataB !== e.b) begin
        n_bad++;
        $display("FAIL %s: got A=%02h B=%02h, want A=%02h B=%02h",
                 e.nm, bus.RdDataA, bus.RdDataB, e.a, e.b);
      end
    end
  end

  task automatic drive(input logic cen, input logic wen, input logic [2:0] wa,
                       input logic [7:0] wd, input logic [2:0] ra, input logic [2:0] rb);
    bus.Cen     = cen;
    bus.WrEn    = wen;
    bus.WrAddr  = wa;
    bus.WrData  = wd;
    bus.RdAddrA = ra;
    bus.RdAddrB = rb;
  endtask

  // Queue the expected reads for the current inputs, then let the next negedge commit.
  task automatic step(input logic [7:0] ea, input logic [7:0] eb, input string nm);
    exp_t e;
    e.a  = ea;
    e.b  = eb;
    e.nm = nm;
    q.push_back(e);
    @(negedge Clk);
    #1;
  endtask

  task automatic idle();
    @(negedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ev;
    n_cmp = 0;
    n_bad = 0;
    Rst   = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    idle();
    Rst = 1'b0;

    // Reset state, including out-of-range addresses 6 and 7.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
      step(8'h00, 8'h00, "rst_state");
    end

    // Fill every register with 0xFF; reg0 stays hard-wired.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 3'(i), 8'hFF, 3'd0, 3'd0);
      idle();
    end
    drive(1'b1, 1'b1, 3'd7, 8'h77, 3'd7, 3'd6);
    step(8'h00, 8'h00, "oor_wr_pre");
    for (int i = 0; i < 8; i++) begin
      ev = (i >= 1 && i <= 5) ? 8'hFF : 8'h00;
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'(i), 3'(i));
      step(ev, ev, "fill_ff");
    end

    // Single-edge reset wipes everything, and wins over a concurrent write.
    Rst = 1'b1;
    drive(1'b1, 1'b1, 3'd2, 8'hAB, 3'd0, 3'd0);
    idle();
    Rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
      step(8'h00, 8'h00, "rst_wipe");
    end

    // Write latency and (optional) forwarding.
    drive(1'b1, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd0);
    step(Bp ? 8'hA5 : 8'h00, 8'h00, "wr3_pre");
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3);
    step(8'hA5, 8'hA5, "wr3_post");

    // Register 0 is hard-wired: never stored, never forwarded.
    drive(1'b1, 1'b1, 3'd0, 8'h5A, 3'd0, 3'd3);
    step(8'h00, 8'hA5, "zero_pre");
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    step(8'h00, 8'h00, "zero_post");

    // Cen low freezes state and queues nothing.
    drive(1'b1, 1'b1, 3'd5, 8'h11, 3'd5, 3'd5);
    step(Bp ? 8'h11 : 8'h00, Bp ? 8'h11 : 8'h00, "r5_pre");
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 3'd5, 8'h3C, 3'd5, 3'd5);
      step(8'h11, 8'h11, "cen_off");
    end
    drive(1'b1, 1'b0, 3'd5, 8'h3C, 3'd5, 3'd5);
    step(8'h11, 8'h11, "cen_on");

    // Two independent read ports, and both on the same register.
    drive(1'b1, 1'b1, 3'd1, 8'h12, 3'd1, 3'd2);
    idle();
    drive(1'b1, 1'b1, 3'd2, 8'h34, 3'd1, 3'd2);
    step(8'h12, Bp ? 8'h34 : 8'h00, "r2_pre");
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2);
    step(8'h12, 8'h34, "pair");
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2);
    step(8'h34, 8'h34, "same_reg");

    // Reset together with a write to r2: reset wins, nothing forwarded.
    Rst = 1'b1;
    drive(1'b1, 1'b1, 3'd2, 8'h99, 3'd2, 3'd1);
    step(8'h34, 8'h12, "rst_wr_pre");
    Rst = 1'b0;
    drive(1'b1, 1'b1, 3'd4, 8'h42, 3'd2, 3'd4);
    step(8'h00, Bp ? 8'h42 : 8'h00, "post_rst");
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd4, 3'd1);
    step(8'h42, 8'h00, "first_wr");

    // Drain the scoreboard within a bounded number of cycles.
    for (int c = 0; c < 8 && q.size() > 0; c++) begin
      @(negedge Clk);
    end
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
